// File: rtl/prog_loader_ctrl_pkg.sv
// Shared header encoding and state codes for the program loader / run sequencer.
package prog_loader_ctrl_pkg;

   localparam logic [7:0] MAGIC_LOAD = 8'hA5;
   localparam logic [7:0] MAGIC_RUN  = 8'h5A;

   // Header field positions: magic in the top byte, LOAD base and count below it.
   localparam int MAGIC_LSB = 24;
   localparam int BASE_LSB  = 11;
   localparam int COUNT_LSB = 0;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   function automatic logic [7:0] hdr_magic(input logic [31:0] word);
      return word[MAGIC_LSB +: 8];
   endfunction

endpackage

// File: rtl/prog_loader_ctrl.sv
// Boot/run sequencer: streams a program into instruction memory with the core held off,
// then enables the core for a bounded (or unbounded) number of cycles.
module prog_loader_ctrl
   import prog_loader_ctrl_pkg::*;
#(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   // Stream handshake: a word transfers on a rising edge where s_valid and s_ready are both high;
   // s_ready never depends on s_valid, and abort forces s_ready low in the same cycle.
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              abort,
   output logic              cpu_en,
   output logic              w_enable,
   output logic [ADDR_W-1:0] w_adrs,
   output logic [DATA_W-1:0] w_instruction,
   output logic              busy,
   output logic              done,
   output logic              err
);

   logic [1:0]        state;
   logic [ADDR_W-1:0] next_adrs;
   logic [ADDR_W-1:0] remaining;
   logic [CNT_W-1:0]  run_cnt;
   logic              run_free;

   logic              accept;
   logic [7:0]        magic;
   logic [ADDR_W-1:0] hdr_base;
   logic [ADDR_W-1:0] hdr_count;
   logic [CNT_W-1:0]  hdr_budget;

   assign s_ready    = ((state == ST_IDLE) || (state == ST_LOAD)) && !abort;
   assign accept     = s_valid && s_ready;
   assign busy       = (state != ST_IDLE);
   assign magic      = hdr_magic(s_data[31:0]);
   assign hdr_base   = s_data[BASE_LSB +: ADDR_W];
   assign hdr_count  = s_data[COUNT_LSB +: ADDR_W];
   assign hdr_budget = s_data[CNT_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         next_adrs     <= '0;
         remaining     <= '0;
         run_cnt       <= '0;
         run_free      <= 1'b0;
         cpu_en        <= 1'b0;
         w_enable      <= 1'b0;
         w_adrs        <= '0;
         w_instruction <= '0;
         done          <= 1'b0;
         err           <= 1'b0;
      end else begin
         w_enable <= 1'b0;
         done     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (magic == MAGIC_LOAD) begin
                     // A zero-length load is accepted but leaves the loader idle.
                     if (hdr_count != '0) begin
                        state     <= ST_LOAD;
                        next_adrs <= hdr_base;
                        remaining <= hdr_count;
                     end
                  end else if (magic == MAGIC_RUN) begin
                     state    <= ST_RUN;
                     cpu_en   <= 1'b1;
                     run_cnt  <= hdr_budget;
                     run_free <= (hdr_budget == '0);
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else if (accept) begin
                  w_enable      <= 1'b1;
                  w_adrs        <= next_adrs;
                  w_instruction <= s_data;
                  next_adrs     <= next_adrs + ADDR_W'(1);
                  remaining     <= remaining - ADDR_W'(1);
                  if (remaining == ADDR_W'(1)) begin
                     state <= ST_IDLE;
                  end
               end
            end
            ST_RUN: begin
               // Abort outranks budget expiry, so an aborted run never pulses done.
               if (abort) begin
                  state  <= ST_IDLE;
                  cpu_en <= 1'b0;
               end else if (!run_free) begin
                  run_cnt <= run_cnt - CNT_W'(1);
                  if (run_cnt == CNT_W'(1)) begin
                     state  <= ST_DONE;
                     cpu_en <= 1'b0;
                     done   <= 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Directed bench for prog_loader_ctrl: transaction-level model checked every cycle,
// plus literal expectations on captured writes and cpu_en/done counts.
module tb_prog_loader_ctrl;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [DATA_W-1:0] s_data = '0;
   logic              abort = 1'b0;
   logic              cpu_en;
   logic              w_enable;
   logic [ADDR_W-1:0] w_adrs;
   logic [DATA_W-1:0] w_instruction;
   logic              busy;
   logic              done;
   logic              err;

   int n_vec = 0;
   int n_err = 0;

   prog_loader_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .abort(abort), .cpu_en(cpu_en), .w_enable(w_enable), .w_adrs(w_adrs),
      .w_instruction(w_instruction), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: what the sequencer is doing, in terms of words left to load and cycles left to run.
   bit             started = 1'b0;
   int             m_load_left = 0;
   int             m_load_addr = 0;
   bit             m_running = 1'b0;
   bit             m_forever = 1'b0;
   int             m_run_left = 0;
   bit             m_done = 1'b0;
   bit             m_err = 1'b0;
   bit             m_wr = 1'b0;
   int             m_wr_adrs = 0;
   logic [31:0]    m_wr_data = '0;

   function automatic bit m_idle();
      return !m_running && (m_load_left == 0) && !m_done;
   endfunction

   function automatic bit m_ready();
      return (m_idle() || (m_load_left > 0)) && !abort;
   endfunction

   always @(posedge clk) begin
      bit take;
      take = s_valid && m_ready();
      started = 1'b1;
      if (reset) begin
         m_load_left = 0; m_load_addr = 0; m_running = 0; m_forever = 0;
         m_run_left = 0; m_done = 0; m_err = 0; m_wr = 0;
      end else begin
         m_wr = 1'b0;
         if (m_done) begin
            m_done = 1'b0;
         end else if (m_running) begin
            if (abort) begin
               m_running = 1'b0;
            end else if (!m_forever) begin
               m_run_left--;
               if (m_run_left == 0) begin
                  m_running = 1'b0;
                  m_done = 1'b1;
               end
            end
         end else if (m_load_left > 0) begin
            if (abort) begin
               m_load_left = 0;
            end else if (take) begin
               m_wr = 1'b1;
               m_wr_adrs = m_load_addr % 2048;
               m_wr_data = s_data;
               m_load_addr++;
               m_load_left--;
            end
         end else if (take) begin
            case (s_data[31:24])
               8'hA5: begin
                  m_load_left = int'(s_data[10:0]);
                  m_load_addr = int'(s_data[21:11]);
               end
               8'h5A: begin
                  m_running = 1'b1;
                  m_run_left = int'(s_data[15:0]);
                  m_forever = (m_run_left == 0);
               end
               default: m_err = 1'b1;
            endcase
         end
      end
   end

   // Observed activity, used by the literal expectations.
   logic [ADDR_W-1:0] log_a[$];
   logic [DATA_W-1:0] log_d[$];
   int                cpu_cycles = 0;
   int                done_cnt = 0;

   always @(negedge clk) begin
      if (started) begin
         check("cpu_en", 64'(cpu_en), 64'(m_running));
         check("w_enable", 64'(w_enable), 64'(m_wr));
         if (m_wr) begin
            check("w_adrs", 64'(w_adrs), 64'(m_wr_adrs));
            check("w_instruction", 64'(w_instruction), 64'(m_wr_data));
         end
         check("busy", 64'(busy), 64'(!m_idle()));
         check("done", 64'(done), 64'(m_done));
         check("err", 64'(err), 64'(m_err));
         check("s_ready", 64'(s_ready), 64'(m_ready()));
         if (w_enable === 1'b1) begin
            log_a.push_back(w_adrs);
            log_d.push_back(w_instruction);
         end
         if (cpu_en === 1'b1) cpu_cycles++;
         if (done === 1'b1) done_cnt++;
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [31:0] word, input int gap);
      bit acc;
      int n;
      acc = 1'b0;
      n = 0;
      s_valid = 1'b1;
      s_data = word;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = s_ready;
         @(posedge clk);
         #1;
         n++;
      end
      check("send_accepted", 64'(acc), 64'd1);
      s_valid = 1'b0;
      idle(gap);
   endtask

   task automatic clear_logs();
      log_a.delete();
      log_d.delete();
      cpu_cycles = 0;
      done_cnt = 0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_cpu_en", 64'(cpu_en), 64'd0);
      check("rst_w_enable", 64'(w_enable), 64'd0);
      check("rst_w_adrs", 64'(w_adrs), 64'd0);
      check("rst_w_instruction", 64'(w_instruction), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_s_ready", 64'(s_ready), 64'd1);
      @(posedge clk);
      #1;

      // LOAD base=0x004 N=3
      clear_logs();
      send(32'hA500_2003, 0);
      send(32'hF000_0000, 0);
      send(32'hF080_1001, 1);
      send(32'hF100_2002, 0);
      idle(3);
      check("load3_count", 64'(log_a.size()), 64'd3);
      if (log_a.size() == 3) begin
         check("load3_a0", 64'(log_a[0]), 64'h004);
         check("load3_a1", 64'(log_a[1]), 64'h005);
         check("load3_a2", 64'(log_a[2]), 64'h006);
         check("load3_d0", 64'(log_d[0]), 64'hF000_0000);
         check("load3_d1", 64'(log_d[1]), 64'hF080_1001);
         check("load3_d2", 64'(log_d[2]), 64'hF100_2002);
      end

      // LOAD wrapping past the top of instruction memory
      clear_logs();
      send(32'hA53F_F802, 0);
      send(32'h1111_1111, 0);
      send(32'h2222_2222, 0);
      idle(3);
      check("wrap_count", 64'(log_a.size()), 64'd2);
      if (log_a.size() == 2) begin
         check("wrap_a0", 64'(log_a[0]), 64'h7FF);
         check("wrap_a1", 64'(log_a[1]), 64'h000);
      end

      // RUN budget=5
      clear_logs();
      send(32'h5A00_0005, 0);
      idle(8);
      check("run5_cpu_cycles", 64'(cpu_cycles), 64'd5);
      check("run5_done_pulses", 64'(done_cnt), 64'd1);
      check("run5_busy_after", 64'(busy), 64'd0);

      // RUN budget=3, abort lands on the expiry edge
      clear_logs();
      send(32'h5A00_0003, 0);
      idle(2);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      idle(3);
      check("abort_exp_cpu_cycles", 64'(cpu_cycles), 64'd3);
      check("abort_exp_done_pulses", 64'(done_cnt), 64'd0);

      // Unknown magic sets sticky err, later LOAD still works
      clear_logs();
      send(32'h1200_0000, 0);
      idle(2);
      check("badhdr_err", 64'(err), 64'd1);
      check("badhdr_ready", 64'(s_ready), 64'd1);
      check("badhdr_writes", 64'(log_a.size()), 64'd0);
      send(32'hA500_8001, 0);
      send(32'hABCD_0123, 0);
      idle(3);
      check("after_bad_writes", 64'(log_a.size()), 64'd1);
      if (log_a.size() == 1) check("after_bad_a0", 64'(log_a[0]), 64'h010);
      check("after_bad_err", 64'(err), 64'd1);

      // LOAD N=4 with gaps, abort after the 2nd word while a 3rd is offered
      clear_logs();
      send(32'hA501_0004, 1);
      send(32'hC000_0001, 2);
      send(32'hC000_0002, 1);
      s_valid = 1'b1;
      s_data = 32'hC000_0003;
      abort = 1'b1;
      @(negedge clk);
      check("abort_s_ready", 64'(s_ready), 64'd0);
      @(posedge clk);
      #1;
      abort = 1'b0;
      s_valid = 1'b0;
      idle(3);
      check("abort_writes", 64'(log_a.size()), 64'd2);
      if (log_a.size() == 2) begin
         check("abort_a0", 64'(log_a[0]), 64'h020);
         check("abort_a1", 64'(log_a[1]), 64'h021);
      end
      check("abort_busy", 64'(busy), 64'd0);

      // Unbounded RUN, then reset
      clear_logs();
      send(32'h5A00_0000, 0);
      idle(100);
      check("free_cpu_cycles", 64'(cpu_cycles), 64'd100);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_run_cpu_en", 64'(cpu_en), 64'd0);
      check("rst_run_err", 64'(err), 64'd0);
      check("rst_run_busy", 64'(busy), 64'd0);
      #1 reset = 1'b0;
      idle(3);
      check("free_done_pulses", 64'(done_cnt), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
